bank_mapper: RTL and testbench



---
 rtl/bank_mapper_pkg.sv | 22 ++
 rtl/bank_mapper_wait_gen.sv | 46 ++++
 rtl/bank_mapper.sv | 141 ++++++++++++++
 tb/tb_bank_mapper.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_mapper_pkg.sv
// Shared constants and types for the bank_mapper address decoder.
package bank_mapper_pkg;

   // IO port map (IO port = low byte of the CPU address)
   localparam logic [7:0] UART_BASE = 8'h70;
   localparam logic [7:0] CTRL_BASE = 8'h74;
   localparam logic [7:0] PAGE_BASE = 8'h78;
   localparam logic [7:0] CTRL_PORT = 8'h7E;
   localparam logic [7:0] BANK_PORT = 8'h7F;

   // Bit positions inside the ctrl register
   localparam int ROM_DIS_BIT = 0;
   localparam int MAP_EN_BIT  = 1;

   // Access region, used to pick the wait-state count
   typedef enum logic [1:0] {
      REG_ROM,
      REG_RAM,
      REG_IO
   } region_e;

endpackage

// File: rtl/bank_mapper_wait_gen.sv
// Wait-state generator: detects the leading edge of a CPU request and holds
// wait_n low for exactly w cycles of that request.
module bank_mapper_wait_gen (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req,
   input  logic [2:0] w,
   output logic       wait_n
);

   logic       req_q, req_d;
   logic [2:0] cnt_q, cnt_d;
   logic       start;

   // Edge detect, counter next state and the combinational wait request
   always_comb begin
      req_d  = req;
      cnt_d  = cnt_q;
      wait_n = 1'b1;
      start  = req & ~req_q;
      if (!req) begin
         cnt_d = '0;
      end else if (start) begin
         if (w != 3'd0) begin
            wait_n = 1'b0;
            cnt_d  = w - 3'd1;
         end
      end else if (cnt_q != 3'd0) begin
         wait_n = 1'b0;
         cnt_d  = cnt_q - 3'd1;
      end
   end

   // req_q resets high so a request still held across reset cannot
   // retrigger a wait; the CPU must drop it first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q <= 1'b1;
         cnt_q <= '0;
      end else begin
         req_q <= req_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bank_mapper.sv
// Z80 address decoder with ROM overlay, 16 KiB paging, banked IO channels
// and per-region wait states.
module bank_mapper
   import bank_mapper_pkg::*;
#(
   parameter int          NUM_IO_CH = 4,
   parameter int          PHYS_AW   = 20,
   parameter logic [15:0] ROM_TOP   = 16'h2000,
   parameter int          ROM_WAIT  = 1,
   parameter int          RAM_WAIT  = 0,
   parameter int          IO_WAIT   = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_n,
   input  logic [15:0]          addr_i,
   input  logic [7:0]           data_i,
   input  logic                 mreq_n,
   input  logic                 ioreq_n,
   output logic [7:0]           data_o,
   output logic [PHYS_AW-1:0]   phys_addr_o,
   output logic                 ram_cs,
   output logic                 rom_cs,
   output logic                 uart_cs,
   output logic                 ctrl_cs,
   output logic [NUM_IO_CH-1:0] io_cs,
   output logic                 wait_n
);

   localparam int PW = PHYS_AW - 14;

   logic [PW-1:0] page_q [4];
   logic [PW-1:0] page_d [4];
   logic [1:0]    ctrl_q, ctrl_d;
   logic [7:0]    io_bank_q, io_bank_d;

   logic [7:0] port;
   logic       mem_req, io_req, in_uart, in_ctrl, is_page, rom_hit;
   region_e    region;
   logic [2:0] wait_cnt;

   assign port    = addr_i[7:0];
   assign mem_req = ~mreq_n;
   // Memory requests win when both strobes are low
   assign io_req  = ~ioreq_n & mreq_n;
   assign in_uart = (port >= UART_BASE) && (port < CTRL_BASE);
   assign in_ctrl = (port >= CTRL_BASE) && (port <= BANK_PORT);
   assign is_page = (port[7:2] == PAGE_BASE[7:2]);
   assign rom_hit = (addr_i < ROM_TOP) && !ctrl_q[ROM_DIS_BIT];

   assign rom_cs  = mem_req & rom_hit;
   assign ram_cs  = mem_req & ~rom_hit;
   assign uart_cs = io_req & in_uart;
   assign ctrl_cs = io_req & in_ctrl;

   // One select line per banked IO channel; out-of-range banks select nothing
   generate
      for (genvar gi = 0; gi < NUM_IO_CH; gi++) begin : g_io_cs
         assign io_cs[gi] = io_req & ~in_uart & ~in_ctrl & (io_bank_q == 8'(gi));
      end
   endgenerate

   // Physical address: paged when mapping is enabled, else pass-through
   always_comb begin
      phys_addr_o = PHYS_AW'(addr_i);
      if (ctrl_q[MAP_EN_BIT])
         phys_addr_o = {page_q[addr_i[15:14]], addr_i[13:0]};
   end

   // Register readback; reserved ports read as zero
   always_comb begin
      data_o = '0;
      if (!ioreq_n && in_ctrl) begin
         if (is_page)
            data_o = 8'(page_q[port[1:0]]);
         else if (port == CTRL_PORT)
            data_o = {6'b0, ctrl_q};
         else if (port == BANK_PORT)
            data_o = io_bank_q;
      end
   end

   // Register write decode
   always_comb begin
      page_d    = page_q;
      ctrl_d    = ctrl_q;
      io_bank_d = io_bank_q;
      if (ctrl_cs && !wr_n) begin
         if (is_page)
            page_d[port[1:0]] = PW'(data_i);
         else if (port == CTRL_PORT)
            ctrl_d = data_i[1:0];
         else if (port == BANK_PORT)
            io_bank_d = data_i;
      end
   end

   // Page registers reset to the identity map of the first 64 KiB
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_page
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
               page_q[gi] <= PW'(gi);
            else
               page_q[gi] <= page_d[gi];
         end
      end
   endgenerate

   // Control and IO bank registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         io_bank_q <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         io_bank_q <= io_bank_d;
      end
   end

   // Region of the current access and its wait-state count
   always_comb begin
      region = REG_IO;
      if (mem_req)
         region = rom_hit ? REG_ROM : REG_RAM;
      case (region)
         REG_ROM: wait_cnt = 3'(ROM_WAIT);
         REG_RAM: wait_cnt = 3'(RAM_WAIT);
         default: wait_cnt = 3'(IO_WAIT);
      endcase
   end

   bank_mapper_wait_gen u_wait_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req    (~mreq_n | ~ioreq_n),
      .w      (wait_cnt),
      .wait_n (wait_n)
   );

endmodule

// File: tb/tb_bank_mapper.sv
// Self-checking bench for bank_mapper: directed scenarios plus randomized
// accesses compared against a behavioural model of the register map.
module tb_bank_mapper;

   localparam int N      = 4;
   localparam int AW     = 20;
   localparam int ROMW   = 1;
   localparam int RAMW   = 0;
   localparam int IOW    = 3;
   localparam int ROMTOP = 'h2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_n, mreq_n, ioreq_n;
   logic [15:0] addr;
   logic [7:0]  din, dout;
   logic [AW-1:0] phys;
   logic        ram_cs, rom_cs, uart_cs, ctrl_cs, wait_n;
   logic [N-1:0] io_cs;

   int checks = 0;
   int passed = 0;

   // Behavioural model state
   int m_page [4];
   int m_rom_dis, m_map_en, m_bank;

   bank_mapper #(
      .NUM_IO_CH (N),
      .PHYS_AW   (AW),
      .ROM_TOP   (16'h2000),
      .ROM_WAIT  (ROMW),
      .RAM_WAIT  (RAMW),
      .IO_WAIT   (IOW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wr_n        (wr_n),
      .addr_i      (addr),
      .data_i      (din),
      .mreq_n      (mreq_n),
      .ioreq_n     (ioreq_n),
      .data_o      (dout),
      .phys_addr_o (phys),
      .ram_cs      (ram_cs),
      .rom_cs      (rom_cs),
      .uart_cs     (uart_cs),
      .ctrl_cs     (ctrl_cs),
      .io_cs       (io_cs),
      .wait_n      (wait_n)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_page[i] = i;
      m_rom_dis = 0;
      m_map_en  = 0;
      m_bank    = 0;
   endfunction

   function automatic void model_write(int port, int d);
      if (port >= 'h78 && port <= 'h7B) m_page[port - 'h78] = d % 64;
      else if (port == 'h7E) begin
         m_rom_dis = d % 2;
         m_map_en  = (d / 2) % 2;
      end else if (port == 'h7F) m_bank = d;
   endfunction

   function automatic int m_phys(int a);
      if (m_map_en != 0) return m_page[a / 16384] * 16384 + (a % 16384);
      return a;
   endfunction

   function automatic int m_rd(int port);
      if (port >= 'h78 && port <= 'h7B) return m_page[port - 'h78];
      if (port == 'h7E) return m_rom_dis + 2 * m_map_en;
      if (port == 'h7F) return m_bank;
      return 0;
   endfunction

   function automatic bit m_is_rom(int a);
      return (a < ROMTOP) && (m_rom_dis == 0);
   endfunction

   function automatic int m_wait(bit mem, int a);
      if (mem) return m_is_rom(a) ? ROMW : RAMW;
      return IOW;
   endfunction

   function automatic int m_iocs(int port);
      if (port >= 'h70 && port <= 'h7F) return 0;
      if (m_bank < N) return 1 << m_bank;
      return 0;
   endfunction

   task automatic go_idle();
      mreq_n  = 1'b1;
      ioreq_n = 1'b1;
      wr_n    = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic io_write(int port, int d);
      mreq_n = 1'b1; ioreq_n = 1'b0; wr_n = 1'b0;
      addr = 16'(port); din = 8'(d);
      @(posedge clk); #1;
      model_write(port, d);
      go_idle();
   endtask

   task automatic test_reset();
      checks++;
      if (wait_n !== 1'b1) $display("FAIL reset_wait: got %b want 1", wait_n); else passed++;
      addr = 16'h1234;
      #1;
      checks++;
      if (phys !== 20'h01234) $display("FAIL reset_phys: got %h want 01234", phys); else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      go_idle();
      for (int p = 'h78; p <= 'h7F; p++) begin
         mreq_n = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; addr = 16'(p);
         @(negedge clk);
         checks++;
         if (dout !== 8'(m_rd(p))) $display("FAIL reset_reg%0h: got %h want %h", p, dout, 8'(m_rd(p)));
         else passed++;
         @(posedge clk); #1;
         go_idle();
      end
   endtask

   task automatic test_rom_overlay();
      int lows;
      for (int pass = 0; pass < 2; pass++) begin
         lows = 0;
         mreq_n = 1'b0; ioreq_n = 1'b1; wr_n = 1'b1; addr = 16'h1000;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wait_n === 1'b0) lows++;
            if (k == 0) begin
               checks++;
               if (pass == 0 && (rom_cs !== 1'b1 || ram_cs !== 1'b0 || phys !== 20'h01000))
                  $display("FAIL rom_sel: got rom=%b ram=%b phys=%h want rom=1 ram=0 phys=01000", rom_cs, ram_cs, phys);
               else if (pass == 1 && (rom_cs !== 1'b0 || ram_cs !== 1'b1))
                  $display("FAIL ram_sel: got rom=%b ram=%b want rom=0 ram=1", rom_cs, ram_cs);
               else passed++;
            end
            @(posedge clk); #1;
         end
         checks++;
         if (lows != (pass == 0 ? 1 : 0))
            $display("FAIL mem_wait%0d: got %0d low cycles want %0d", pass, lows, (pass == 0 ? 1 : 0));
         else passed++;
         go_idle();
         if (pass == 0) io_write('h7E, 'h01);
      end
   endtask

   task automatic test_paging();
      io_write('h7E, 'h02);
      io_write('h7B, 'h2A);
      mreq_n = 1'b0; ioreq_n = 1'b1; wr_n = 1'b1; addr = 16'hC123;
      @(negedge clk);
      checks++;
      if (phys !== 20'hA8123) $display("FAIL paged_phys: got %h want A8123", phys); else passed++;
      @(posedge clk); #1;
      go_idle();
      mreq_n = 1'b1; ioreq_n = 1'b0; addr = 16'h007B;
      @(negedge clk);
      checks++;
      if (dout !== 8'h2A) $display("FAIL page_rd: got %h want 2A", dout); else passed++;
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_io_bank();
      io_write('h7F, 'h02);
      mreq_n = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; addr = 16'h0010;
      @(negedge clk);
      checks++;
      if (io_cs !== 4'b0100) $display("FAIL io_bank2: got %b want 0100", io_cs); else passed++;
      @(posedge clk); #1;
      go_idle();
      io_write('h7F, 'h05);
      ioreq_n = 1'b0; addr = 16'h0010;
      @(negedge clk);
      checks++;
      if (io_cs !== 4'b0000) $display("FAIL io_bank5: got %b want 0000", io_cs); else passed++;
      @(posedge clk); #1;
      go_idle();
      ioreq_n = 1'b0; addr = 16'h0071;
      @(negedge clk);
      checks++;
      if (uart_cs !== 1'b1 || ctrl_cs !== 1'b0 || io_cs !== 4'b0000)
         $display("FAIL uart_sel: got uart=%b ctrl=%b io=%b want 1 0 0000", uart_cs, ctrl_cs, io_cs);
      else passed++;
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_io_wait();
      mreq_n = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; addr = 16'h0080;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (wait_n !== ((k < IOW) ? 1'b0 : 1'b1))
            $display("FAIL io_wait_c%0d: got %b want %b", k, wait_n, ((k < IOW) ? 1'b0 : 1'b1));
         else passed++;
         @(posedge clk); #1;
      end
      go_idle();
      ioreq_n = 1'b0;
      @(negedge clk);
      checks++;
      if (wait_n !== 1'b0) $display("FAIL drop_c0: got %b want 0", wait_n); else passed++;
      @(posedge clk); #1;
      ioreq_n = 1'b1;
      @(negedge clk);
      checks++;
      if (wait_n !== 1'b1) $display("FAIL drop_c1: got %b want 1", wait_n); else passed++;
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_reset_mid_wait();
      io_write('h7B, 'h15);
      io_write('h7E, 'h03);
      io_write('h7F, 'h02);
      mreq_n = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; addr = 16'h0080;
      @(posedge clk); #1;
      checks++;
      if (wait_n !== 1'b0) $display("FAIL pre_rst_wait: got %b want 0", wait_n); else passed++;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (wait_n !== 1'b1) $display("FAIL rst_wait: got %b want 1", wait_n); else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      go_idle();
      for (int p = 'h78; p <= 'h7F; p++) begin
         if (p == 'h7C || p == 'h7D) continue;
         ioreq_n = 1'b0; addr = 16'(p);
         @(negedge clk);
         checks++;
         if (dout !== 8'(p < 'h7C ? p - 'h78 : 0))
            $display("FAIL rst_reg%0h: got %h want %h", p, dout, 8'(p < 'h7C ? p - 'h78 : 0));
         else passed++;
         @(posedge clk); #1;
         go_idle();
      end
   endtask

   task automatic test_both_low();
      mreq_n = 1'b0; ioreq_n = 1'b0; wr_n = 1'b1; addr = 16'h0075;
      @(negedge clk);
      checks++;
      if (rom_cs !== 1'b1 || ram_cs !== 1'b0 || ctrl_cs !== 1'b0 || uart_cs !== 1'b0 || io_cs !== 4'b0000)
         $display("FAIL both_low: got rom=%b ram=%b ctrl=%b uart=%b io=%b want 1 0 0 0 0000",
                  rom_cs, ram_cs, ctrl_cs, uart_cs, io_cs);
      else passed++;
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_random();
      int kind, a, port, d, len, ew, bad;
      bit mem, wr;
      bit [7:0] e_dout;
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 3);
         a    = $urandom_range(0, 'hFFFF);
         d    = $urandom_range(0, 255);
         len  = $urandom_range(1, 5);
         mem  = (kind == 0);
         wr   = 1'b0;
         if (kind == 1) a = (a & 'hFF00) | $urandom_range('h70, 'h7F);
         if (kind == 2) begin
            a  = (a & 'hFF00) | $urandom_range('h78, 'h7F);
            wr = 1'b1;
            if ((a & 'hFF) == 'h7E) d = d & 'h3;
         end
         port = a & 'hFF;
         ew   = m_wait(mem, a);
         bad  = 0;
         mreq_n = !mem; ioreq_n = mem; wr_n = !wr;
         addr = 16'(a); din = 8'(d);
         for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e_dout = (!mem && port >= 'h74) && port <= 'h7F ? 8'(m_rd(port)) : 8'h00;
            checks++;
            if (rom_cs !== (mem && m_is_rom(a)) || ram_cs !== (mem && !m_is_rom(a)) ||
                uart_cs !== (!mem && port >= 'h70 && port <= 'h73) ||
                ctrl_cs !== (!mem && port >= 'h74 && port <= 'h7F) ||
                io_cs !== (mem ? 4'b0 : 4'(m_iocs(port))) ||
                phys !== 20'(m_phys(a)) || dout !== e_dout ||
                wait_n !== ((k < ew) ? 1'b0 : 1'b1)) begin
               bad++;
               $display("FAIL rand_t%0d_c%0d: got rom=%b ram=%b uart=%b ctrl=%b io=%b phys=%h dout=%h wait=%b want io=%b phys=%h dout=%h wait=%b",
                        t, k, rom_cs, ram_cs, uart_cs, ctrl_cs, io_cs, phys, dout, wait_n,
                        (mem ? 4'b0 : 4'(m_iocs(port))), 20'(m_phys(a)), e_dout, ((k < ew) ? 1'b0 : 1'b1));
            end else passed++;
            @(posedge clk); #1;
            if (wr) model_write(port, d);
         end
         $display("txn %0d: %s addr=%h wr=%0d data=%h len=%0d wait=%0d errors=%0d",
                  t, mem ? "mem" : "io ", a, wr, d, len, ew, bad);
         go_idle();
      end
   endtask

   initial begin
      rst = 1'b1; mreq_n = 1'b1; ioreq_n = 1'b1; wr_n = 1'b1;
      addr = '0; din = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_rom_overlay();
      test_paging();
      test_io_bank();
      test_io_wait();
      test_reset_mid_wait();
      test_both_low();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish before limit");
      $fatal(1, "timeout");
   end

endmodule
